// File: rtl/mode_select.sv
// mode_select: synchronises and debounces NEXT/PREV buttons and steps a wrapping 2-bit mode
module mode_select #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 19,
  parameter int NUM_MODES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next_raw,
  input  logic       btn_prev_raw,
  input  logic       lock,
  output logic [1:0] mode,
  output logic       mode_changed
);
  localparam logic [1:0] TOP = 2'(NUM_MODES - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [1:0] raw, s1, s2, deb, deb_d, ev;
  logic [CNT_W-1:0] cnt [2];
  logic nxt, prv, step;
  logic [1:0] mode_nx;
  assign raw = {btn_prev_raw, btn_next_raw};
  // channel 0 is NEXT, channel 1 is PREV
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        s1[i] <= 1'b0;
        s2[i] <= 1'b0;
        deb[i] <= 1'b0;
        deb_d[i] <= 1'b0;
        cnt[i] <= '0;
      end else begin
        s1[i] <= raw[i];
        s2[i] <= s1[i];
        deb_d[i] <= deb[i];
        if (s2[i] == deb[i]) cnt[i] <= '0;
        else if (cnt[i] == LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else cnt[i] <= cnt[i] + 1'b1;
      end
    end
  end
  assign ev = deb & ~deb_d;
  assign nxt = ev[0];
  assign prv = ev[1];
  assign step = !lock && (nxt ^ prv);
  always_comb
    mode_nx = nxt ? ((mode == TOP) ? 2'd0 : mode + 2'd1)
                  : ((mode == 2'd0) ? TOP : mode - 2'd1);
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode <= 2'd0;
      mode_changed <= 1'b0;
    end else begin
      mode_changed <= step;
      if (step) mode <= mode_nx;
    end
  end
endmodule

// File: tb/tb_mode_select.sv
// tb_mode_select: directed checks of debounce latency, wrap, glitch rejection, lock and reset
module tb_mode_select;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_next_raw = 1'b0;
  logic btn_prev_raw = 1'b0;
  logic lock = 1'b0;
  logic [1:0] mode;
  logic mode_changed;
  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  mode_select #(.DEBOUNCE_CYCLES(4), .CNT_W(3), .NUM_MODES(3)) dut (
    .clk(clk), .reset(reset), .btn_next_raw(btn_next_raw),
    .btn_prev_raw(btn_prev_raw), .lock(lock), .mode(mode),
    .mode_changed(mode_changed)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      pulses += int'(mode_changed);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(2);
    check("reset_mode", mode, 0);
    check("reset_pulse", mode_changed, 0);
    reset = 1'b1;
  endtask

  task automatic press(input bit nx, input bit pv);
    btn_next_raw = nx;
    btn_prev_raw = pv;
    cyc(10);
    btn_next_raw = 1'b0;
    btn_prev_raw = 1'b0;
    cyc(10);
  endtask

  initial begin
    // 1: reset then hold NEXT, mode steps on edge 7 only
    @(negedge clk);
    do_reset();
    btn_next_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("t1_mode_e%0d", k), mode, (k >= 7) ? 1 : 0);
      check($sformatf("t1_pulse_e%0d", k), mode_changed, (k == 7) ? 1 : 0);
    end
    btn_next_raw = 1'b0;
    pulses = 0;
    cyc(12);
    check("t1_release_pulses", pulses, 0);
    check("t1_release_mode", mode, 1);
    // 2: three NEXT presses wrap, then PREV from 0
    do_reset();
    pulses = 0;
    press(1, 0);
    check("t2_next1", mode, 1);
    press(1, 0);
    check("t2_next2", mode, 2);
    press(1, 0);
    check("t2_next3_wrap", mode, 0);
    check("t2_pulses", pulses, 3);
    press(0, 1);
    check("t2_prev_wrap", mode, 2);
    // 3: short glitches never pass the debouncer
    do_reset();
    pulses = 0;
    for (int r = 0; r < 10; r++) begin
      btn_next_raw = 1'b1;
      cyc(3);
      btn_next_raw = 1'b0;
      cyc(2);
    end
    cyc(10);
    check("t3_glitch_mode", mode, 0);
    check("t3_glitch_pulses", pulses, 0);
    // 4: simultaneous press cancels, then a lone PREV re-press steps down
    pulses = 0;
    btn_next_raw = 1'b1;
    btn_prev_raw = 1'b1;
    cyc(20);
    check("t4_both_mode", mode, 0);
    check("t4_both_pulses", pulses, 0);
    btn_prev_raw = 1'b0;
    cyc(10);
    btn_prev_raw = 1'b1;
    cyc(10);
    check("t4_prev_mode", mode, 2);
    check("t4_prev_pulses", pulses, 1);
    btn_next_raw = 1'b0;
    btn_prev_raw = 1'b0;
    cyc(10);
    check("t4_release_mode", mode, 2);
    // 5: presses during lock are lost
    pulses = 0;
    lock = 1'b1;
    press(1, 0);
    press(1, 0);
    check("t5_locked_mode", mode, 2);
    check("t5_locked_pulses", pulses, 0);
    lock = 1'b0;
    press(1, 0);
    check("t5_unlocked_mode", mode, 0);
    check("t5_unlocked_pulses", pulses, 1);
    // 6: reset mid-debounce leaves no residue
    press(1, 0);
    check("t6_pre_mode", mode, 1);
    btn_next_raw = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    btn_next_raw = 1'b0;
    do_reset();
    pulses = 0;
    cyc(20);
    check("t6_post_mode", mode, 0);
    check("t6_post_pulses", pulses, 0);
    // button held across reset release counts once
    btn_next_raw = 1'b1;
    do_reset();
    pulses = 0;
    cyc(20);
    check("t6_held_mode", mode, 1);
    check("t6_held_pulses", pulses, 1);
    btn_next_raw = 1'b0;
    cyc(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
